instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Stream-in, stream-out RV32I instruction encoder; the inverse of the control unit's opcode/funct3 decode.
- Accepts instruction fields (format, funct3, register indices, 32-bit immediate) over a valid/ready handshake.
- Checks legality against the decoder's supported instruction set, packs a 32-bit instruction word, and emits it with an auto-incrementing instruction-memory address.
- Used by the program loader and by the testbench to fill instruction memory.

Parameters:
DATA_WIDTH, 32, instruction word width; fixed at 32
ADDR_WIDTH, 32, output address width
BASE_ADDR, 0, address of the first emitted word after reset
ERR_WIDTH, 8, width of the saturating error counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  field beat valid
in_ready  output  1  encoder can accept a beat
in_fmt  input  3  0 I-ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 JAL, 5 R-type (optional), 6-7 illegal
in_funct3  input  3  funct3 field
in_rd  input  5  destination register
in_rs1  input  5  source register 1
in_rs2  input  5  source register 2
in_imm  input  32  signed byte immediate/offset
in_funct7b5  input  1  funct7[5]; used only for R-type
out_valid  output  1  encoded word valid
out_ready  input  1  sink accepts word
out_instr  output  DATA_WIDTH  encoded instruction
out_addr  output  ADDR_WIDTH  byte address of out_instr
err_valid  output  1  one-cycle pulse: rejected beat
err_count  output  ERR_WIDTH  saturating count of rejected beats

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - out_valid=0, err_valid=0, err_count=0.
  - Skid buffer empty; address counter=BASE_ADDR.
  - in_ready=1 in the cycle after reset deasserts; in_ready=0 while rst=1.
  - out_instr and out_addr reset to 0.
- Handshakes:
  - Input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready.
  - out_instr and out_addr stay stable while out_valid&&!out_ready.
- Buffering:
  - Two entries: an output register plus one skid register.
  - in_ready is registered and equals "skid empty".
  - A word accepted at cycle N is presented at N+1 if the output register is empty or draining that cycle; otherwise it goes to skid.
  - Order is strictly preserved.
  - Full throughput of 1 word/cycle when out_ready=1.
- Encoding, by format:
  - I-ALU: opcode 0010011, imm[11:0] in bits 31:20.
  - LOAD: opcode 0000011, same layout as I-ALU.
  - STORE: opcode 0100011, imm[11:5] in 31:25, imm[4:0] in 11:7.
  - BRANCH: opcode 1100011, B layout (imm[12|10:5], rs2, rs1, f3, imm[4:1|11]).
  - JAL: opcode 1101111, J layout (imm[20|10:1|11|19:12], rd).
  - Fields not used by a format are ignored; rd is ignored for STORE and BRANCH.
- Legality; any violation is an error:
  - I-ALU: funct3 must be one of {000,010,110,111}; imm in [-2048,2047].
  - LOAD and STORE: funct3 must be 010; imm in [-2048,2047].
  - BRANCH: funct3 must not be 010 or 011; imm in [-4096,4094]; imm[0]=0.
  - JAL: imm in [-1048576,1048574]; imm[0]=0.
  - in_fmt 6-7: always illegal. in_fmt 5: illegal unless the optional feature is compiled in.
- Error handling:
  - The beat is consumed; err_valid pulses at N+1.
  - No output word is produced and the address does not advance.
  - err_count increments and saturates at all-ones.
- Address:
  - out_addr is BASE_ADDR plus 4× the number of words emitted since reset.
  - The counter increments when a word is accepted (not when it is output).
  - Wraps modulo 2^ADDR_WIDTH.
- Simultaneous events:
  - Input accept and output drain in the same cycle: the new word enters the output register directly and the skid stays empty.
  - Error beat while the buffer is full is impossible, because in_ready=0.
- Reset mid-operation: buffered words are discarded, the address returns to BASE_ADDR, and err_count clears.

Optional Feature:
- Macro: ENCODER_RTYPE_EN.
- Defined: in_fmt=5 encodes R-type with opcode 0110011 and funct7 = {1'b0, in_funct7b5, 5'b0}.
  - funct7b5=1 is legal only with funct3 000 or 101; any other combination is an error.
  - in_imm is ignored.
- Undefined: in_fmt=5 is illegal; err_valid pulses and no word is produced.

Test Plan:
- Reset, BASE_ADDR=0, out_ready=1; push I-ALU f3=000 rd=1 rs1=0 imm=5, then LOAD f3=010 rd=2 rs1=1 imm=8 -> words 0x00500093 @0x0 and 0x0080A103 @0x4 on consecutive cycles.
- STORE f3=010 rs1=1 rs2=2 imm=12 -> 0x0020A623; BRANCH f3=000 rs1=1 rs2=2 imm=-8 -> 0xFE208CE3; JAL rd=1 imm=16 -> 0x010000EF.
- I-ALU imm=2048 -> err_valid one cycle, err_count=1, no out_valid; next legal beat gets the next sequential address (no gap). Also: BRANCH imm=6 with f3=010 -> error; JAL imm=3 -> error.
- out_ready=0, push 3 legal beats -> 2 accepted, in_ready=0; raise out_ready -> 3 words in order at addresses +0, +4, +8, with data held stable while stalled.
- Assert rst with 2 words buffered -> next cycle out_valid=0 and err_count=0; first subsequent word is at BASE_ADDR.
- With ENCODER_RTYPE_EN: fmt=5 f3=000 funct7b5=1 rd=3 rs1=1 rs2=2 -> 0x402081B3; without the macro, the same beat -> error.

Source files
------------

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//   Stream-in / stream-out RV32I instruction encoder. Accepts instruction fields
//   over a valid/ready handshake, checks them against the supported instruction
//   set, packs a 32-bit instruction word and emits it with an auto-incrementing
//   byte address. Illegal beats are consumed and flagged instead of emitted.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    field beat handshake (in_ready is registered)
//   in_fmt               0 I-ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 JAL, 5 R-type, 6-7 illegal
//   in_funct3, in_rd, in_rs1, in_rs2, in_imm, in_funct7b5   instruction fields
//   out_valid/out_ready  encoded word handshake
//   out_instr, out_addr  encoded word and its byte address
//   err_valid            one-cycle pulse for a rejected beat
//   err_count            saturating count of rejected beats
//
// Optional feature macro: ENCODER_RTYPE_EN (enables in_fmt=5, R-type encoding).
// -----------------------------------------------------------------------------
module instr_encoder #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int unsigned           ERR_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_fmt,
  input  logic [2:0]            in_funct3,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [31:0]           in_imm,
  input  logic                  in_funct7b5,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  err_valid,
  output logic [ERR_WIDTH-1:0]  err_count
);

  // Encoder results
  logic                  enc_legal_s;
  logic [DATA_WIDTH-1:0] enc_word_s;
  logic                  imm12_ok_s;
  logic                  imm13_ok_s;
  logic                  imm21_ok_s;

  // Handshake qualifiers
  logic accept_s;
  logic push_s;
  logic drain_s;

  // State
  logic                  in_ready_q,   in_ready_d;
  logic                  out_valid_q,  out_valid_d;
  logic [DATA_WIDTH-1:0] out_instr_q,  out_instr_d;
  logic [ADDR_WIDTH-1:0] out_addr_q,   out_addr_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [DATA_WIDTH-1:0] skid_instr_q, skid_instr_d;
  logic [ADDR_WIDTH-1:0] skid_addr_q,  skid_addr_d;
  logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
  logic                  err_valid_q,  err_valid_d;
  logic [ERR_WIDTH-1:0]  err_count_q,  err_count_d;

  // Signed range checks for the I/S (12-bit), B (13-bit) and J (21-bit) immediates
  assign imm12_ok_s = ($signed(in_imm) >= -32'sd2048)    && ($signed(in_imm) <= 32'sd2047);
  assign imm13_ok_s = ($signed(in_imm) >= -32'sd4096)    && ($signed(in_imm) <= 32'sd4094);
  assign imm21_ok_s = ($signed(in_imm) >= -32'sd1048576) && ($signed(in_imm) <= 32'sd1048574);

`ifndef ENCODER_RTYPE_EN
  // funct7[5] only matters for R-type, which is not built in this configuration
  logic unused_funct7b5;
  assign unused_funct7b5 = in_funct7b5;
`endif

  // Field legality check and instruction packing by format
  always_comb begin
    enc_legal_s = 1'b0;
    enc_word_s  = 32'd0;
    case (in_fmt)
      3'd0: begin
        enc_legal_s = (in_funct3 inside {3'b000, 3'b010, 3'b110, 3'b111}) && imm12_ok_s;
        enc_word_s  = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
      end
      3'd1: begin
        enc_legal_s = (in_funct3 == 3'b010) && imm12_ok_s;
        enc_word_s  = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
      end
      3'd2: begin
        enc_legal_s = (in_funct3 == 3'b010) && imm12_ok_s;
        enc_word_s  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
      end
      3'd3: begin
        enc_legal_s = (in_funct3 != 3'b010) && (in_funct3 != 3'b011) && imm13_ok_s
                      && (in_imm[0] == 1'b0);
        enc_word_s  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                       in_imm[4:1], in_imm[11], 7'b1100011};
      end
      3'd4: begin
        enc_legal_s = imm21_ok_s && (in_imm[0] == 1'b0);
        enc_word_s  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
      end
`ifdef ENCODER_RTYPE_EN
      3'd5: begin
        // funct7[5]=1 exists only for SUB (000) and SRA (101)
        enc_legal_s = !in_funct7b5 || (in_funct3 == 3'b000) || (in_funct3 == 3'b101);
        enc_word_s  = {1'b0, in_funct7b5, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
      end
`endif
      default: begin
        enc_legal_s = 1'b0;
        enc_word_s  = 32'd0;
      end
    endcase
  end

  assign accept_s = in_valid && in_ready_q;
  assign push_s   = accept_s && enc_legal_s;
  assign drain_s  = out_valid_q && out_ready;

  // Two-entry buffer (output register + skid), address counter and error tracking
  always_comb begin
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_addr_d   = out_addr_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_addr_d  = skid_addr_q;
    addr_d       = addr_q;
    err_count_d  = err_count_q;

    if (!out_valid_q || drain_s) begin
      // Output register is free this cycle: the skid (older) has priority.
      // in_ready equals "skid empty", so a push never coincides with a full skid.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_instr_d  = skid_instr_q;
        out_addr_d   = skid_addr_q;
        skid_valid_d = 1'b0;
      end else if (push_s) begin
        out_valid_d  = 1'b1;
        out_instr_d  = enc_word_s;
        out_addr_d   = addr_q;
      end else begin
        out_valid_d  = 1'b0;
      end
    end else begin
      if (push_s) begin
        skid_valid_d = 1'b1;
        skid_instr_d = enc_word_s;
        skid_addr_d  = addr_q;
      end else begin
        skid_valid_d = skid_valid_q;
      end
    end

    // Address advances on acceptance of a legal word, not on output
    if (push_s) begin
      addr_d = addr_q + ADDR_WIDTH'(32'd4);
    end else begin
      addr_d = addr_q;
    end

    err_valid_d = accept_s && !enc_legal_s;
    if (err_valid_d && (err_count_q != '1)) begin
      err_count_d = err_count_q + {{(ERR_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      err_count_d = err_count_q;
    end

    in_ready_d = !skid_valid_d;
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_instr_q  <= '0;
      out_addr_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_addr_q  <= '0;
      addr_q       <= BASE_ADDR;
      err_valid_q  <= 1'b0;
      err_count_q  <= '0;
    end else begin
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_addr_q   <= out_addr_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_addr_q  <= skid_addr_d;
      addr_q       <= addr_d;
      err_valid_q  <= err_valid_d;
      err_count_q  <= err_count_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_addr  = out_addr_q;
  assign err_valid = err_valid_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
//   Self-checking bench for instr_encoder: directed vector table, hand-written
//   stall / reset sequences and randomized traffic checked against a
//   behavioural model (arithmetic encoder + expected-word queue).
// -----------------------------------------------------------------------------
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        in_funct7b5;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err_valid;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_funct3(in_funct3), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_funct7b5(in_funct7b5),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .err_valid(err_valid), .err_count(err_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_addr;
  int          model_errs;
  bit          err_pending;
  bit          stall_prev;
  logic [31:0] stall_instr;
  logic [31:0] stall_addr;
  bit          last_acc;

  typedef struct {
    logic [2:0]  fmt;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        f7b5;
    bit          legal;
    logic [31:0] word;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Extract nbits of v starting at bit lsb and place them at bit position 'at'
  function automatic logic [31:0] fld(input int v, input int lsb, input int nbits, input int at);
    int x;
    x = (v >>> lsb) & ((1 << nbits) - 1);
    return 32'(x) << at;
  endfunction

  // Reference encoder computed from the instruction-set rules
  function automatic void ref_enc(input logic [2:0] fmt, input logic [2:0] f3,
                                  input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic [31:0] imm,
                                  input logic f7b5, output bit legal, output logic [31:0] w);
    int s;
    int f;
    s = $signed(imm);
    f = int'(f3);
    legal = 1'b0;
    w = 32'd0;
    if (fmt == 3'd0 || fmt == 3'd1) begin
      legal = (s >= -2048) && (s <= 2047) &&
              ((fmt == 3'd0) ? (f == 0 || f == 2 || f == 6 || f == 7) : (f == 2));
      w = fld(s, 0, 12, 20) | fld(int'(rs1), 0, 5, 15) | fld(f, 0, 3, 12) |
          fld(int'(rd), 0, 5, 7) | ((fmt == 3'd0) ? 32'h13 : 32'h03);
    end else if (fmt == 3'd2) begin
      legal = (s >= -2048) && (s <= 2047) && (f == 2);
      w = fld(s, 5, 7, 25) | fld(int'(rs2), 0, 5, 20) | fld(int'(rs1), 0, 5, 15) |
          fld(f, 0, 3, 12) | fld(s, 0, 5, 7) | 32'h23;
    end else if (fmt == 3'd3) begin
      legal = (s >= -4096) && (s <= 4094) && (s % 2 == 0) && (f != 2) && (f != 3);
      w = fld(s, 12, 1, 31) | fld(s, 5, 6, 25) | fld(int'(rs2), 0, 5, 20) |
          fld(int'(rs1), 0, 5, 15) | fld(f, 0, 3, 12) | fld(s, 1, 4, 8) |
          fld(s, 11, 1, 7) | 32'h63;
    end else if (fmt == 3'd4) begin
      legal = (s >= -1048576) && (s <= 1048574) && (s % 2 == 0);
      w = fld(s, 20, 1, 31) | fld(s, 1, 10, 21) | fld(s, 11, 1, 20) |
          fld(s, 12, 8, 12) | fld(int'(rd), 0, 5, 7) | 32'h6F;
    end else if (fmt == 3'd5) begin
`ifdef ENCODER_RTYPE_EN
      legal = !f7b5 || f == 0 || f == 5;
      w = (f7b5 ? 32'h4000_0000 : 32'h0) | fld(int'(rs2), 0, 5, 20) |
          fld(int'(rs1), 0, 5, 15) | fld(f, 0, 3, 12) | fld(int'(rd), 0, 5, 7) | 32'h33;
`else
      legal = 1'b0;
`endif
    end
  endfunction

  // One clock: check per-cycle outputs, predict the handshakes about to happen, advance
  task automatic cycle();
    bit acc;
    bit drn;
    bit lg;
    logic [31:0] w;
    exp_t e;
    check("err_valid", 32'(err_valid), 32'(err_pending));
    check("err_count", 32'(err_count), 32'(model_errs));
    if (stall_prev) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_instr", out_instr, stall_instr);
      check("stall_addr", out_addr, stall_addr);
    end
    acc = in_valid && in_ready;
    drn = out_valid && out_ready;
    if (drn) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_word: got 0x%08h @0x%08h expected none", out_instr, out_addr);
      end else begin
        e = exp_q.pop_front();
        n_tests--;
        check("out_instr", out_instr, e.instr);
        check("out_addr", out_addr, e.addr);
      end
    end
    stall_prev  = out_valid && !out_ready;
    stall_instr = out_instr;
    stall_addr  = out_addr;
    err_pending = 1'b0;
    last_acc    = acc;
    if (acc) begin
      ref_enc(in_fmt, in_funct3, in_rd, in_rs1, in_rs2, in_imm, in_funct7b5, lg, w);
      if (lg) begin
        e.instr = w;
        e.addr  = model_addr;
        exp_q.push_back(e);
        model_addr = model_addr + 32'd4;
      end else begin
        err_pending = 1'b1;
        if (model_errs < 255) model_errs++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [2:0] fmt, input logic [2:0] f3, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                          input logic f7b5);
    in_valid = 1'b1; in_fmt = fmt; in_funct3 = f3; in_rd = rd;
    in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_funct7b5 = f7b5;
  endtask

  // Keep the current beat asserted until it is accepted (bounded)
  task automatic push_wait();
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!last_acc && n < 50);
    if (!last_acc) check("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_err_valid", 32'(err_valid), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_addr", out_addr, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    model_addr  = 32'd0;
    model_errs  = 0;
    err_pending = 1'b0;
    stall_prev  = 1'b0;
  endtask

  initial begin
    bit          rt;
    logic [31:0] bimm[12];

`ifdef ENCODER_RTYPE_EN
    rt = 1'b1;
`else
    rt = 1'b0;
`endif
    vecs[0]  = '{3'd2, 3'd2, 5'd0, 5'd1, 5'd2, 32'd12,        1'b0, 1'b1, 32'h0020A623};
    vecs[1]  = '{3'd3, 3'd0, 5'd0, 5'd1, 5'd2, -32'sd8,       1'b0, 1'b1, 32'hFE208CE3};
    vecs[2]  = '{3'd4, 3'd0, 5'd1, 5'd0, 5'd0, 32'd16,        1'b0, 1'b1, 32'h010000EF};
    vecs[3]  = '{3'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048,      1'b0, 1'b0, 32'h0};
    vecs[4]  = '{3'd3, 3'd2, 5'd0, 5'd1, 5'd2, 32'd6,         1'b0, 1'b0, 32'h0};
    vecs[5]  = '{3'd4, 3'd0, 5'd1, 5'd0, 5'd0, 32'd3,         1'b0, 1'b0, 32'h0};
    vecs[6]  = '{3'd0, 3'd0, 5'd0, 5'd0, 5'd0, -32'sd2048,    1'b0, 1'b1, 32'h80000013};
    vecs[7]  = '{3'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd2047,      1'b0, 1'b1, 32'h7FF00013};
    vecs[8]  = '{3'd3, 3'd1, 5'd0, 5'd0, 5'd0, 32'd4094,      1'b0, 1'b1, 32'h7E001FE3};
    vecs[9]  = '{3'd3, 3'd0, 5'd0, 5'd0, 5'd0, -32'sd4096,    1'b0, 1'b1, 32'h80000063};
    vecs[10] = '{3'd4, 3'd0, 5'd0, 5'd0, 5'd0, -32'sd1048576, 1'b0, 1'b1, 32'h8000006F};
    vecs[11] = '{3'd3, 3'd0, 5'd0, 5'd0, 5'd0, 32'd4096,      1'b0, 1'b0, 32'h0};
    vecs[12] = '{3'd0, 3'd1, 5'd1, 5'd0, 5'd0, 32'd5,         1'b0, 1'b0, 32'h0};
    vecs[13] = '{3'd6, 3'd0, 5'd1, 5'd0, 5'd0, 32'd0,         1'b0, 1'b0, 32'h0};
    vecs[14] = '{3'd7, 3'd2, 5'd1, 5'd0, 5'd0, 32'd0,         1'b0, 1'b0, 32'h0};
    vecs[15] = '{3'd5, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0,         1'b1, rt,   32'h402081B3};

    bimm = '{32'd2047, 32'd2048, -32'sd2048, -32'sd2049, 32'd4094, 32'd4096,
             -32'sd4096, -32'sd4098, 32'd1048574, 32'd1048576, -32'sd1048576, 32'd3};

    in_valid = 1'b0; in_fmt = 3'd0; in_funct3 = 3'd0; in_rd = 5'd0; in_rs1 = 5'd0;
    in_rs2 = 5'd0; in_imm = 32'd0; in_funct7b5 = 1'b0; out_ready = 1'b1;
    rst = 1'b1;
    #1;
    do_reset();

    // Back-to-back I-ALU then LOAD at full throughput
    set_beat(3'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
    cycle();
    check("tp1_valid", 32'(out_valid), 32'd1);
    check("tp1_instr", out_instr, 32'h00500093);
    check("tp1_addr", out_addr, 32'h0);
    set_beat(3'd1, 3'd2, 5'd2, 5'd1, 5'd0, 32'd8, 1'b0);
    cycle();
    check("tp2_valid", 32'(out_valid), 32'd1);
    check("tp2_instr", out_instr, 32'h0080A103);
    check("tp2_addr", out_addr, 32'h4);
    in_valid = 1'b0;
    cycle();

    // Vector table, one beat at a time
    for (int i = 0; i < 16; i++) begin
      set_beat(vecs[i].fmt, vecs[i].f3, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
               vecs[i].imm, vecs[i].f7b5);
      cycle();
      in_valid = 1'b0;
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].legal));
      check($sformatf("vec%0d_err", i), 32'(err_valid), 32'(!vecs[i].legal));
      if (vecs[i].legal) check($sformatf("vec%0d_instr", i), out_instr, vecs[i].word);
      cycle();
    end

    // Stall: two beats fill the buffer, the third waits; release drains in order
    out_ready = 1'b0;
    set_beat(3'd0, 3'd6, 5'd4, 5'd5, 5'd0, 32'd100, 1'b0);
    cycle();
    set_beat(3'd1, 3'd2, 5'd6, 5'd7, 5'd0, -32'sd4, 1'b0);
    cycle();
    check("stall_in_ready", 32'(in_ready), 32'd0);
    check("stall_depth", 32'(exp_q.size()), 32'd2);
    set_beat(3'd2, 3'd2, 5'd0, 5'd8, 5'd9, 32'd40, 1'b0);
    for (int i = 0; i < 4; i++) cycle();
    check("stall_depth_held", 32'(exp_q.size()), 32'd2);
    out_ready = 1'b1;
    push_wait();
    for (int i = 0; i < 4; i++) cycle();
    check("stall_drained", 32'(exp_q.size()), 32'd0);

    // Reset with two words buffered
    out_ready = 1'b0;
    set_beat(3'd0, 3'd0, 5'd1, 5'd1, 5'd0, 32'd1, 1'b0);
    cycle();
    set_beat(3'd0, 3'd0, 5'd2, 5'd2, 5'd0, 32'd2, 1'b0);
    cycle();
    in_valid = 1'b0;
    do_reset();
    out_ready = 1'b1;
    set_beat(3'd4, 3'd0, 5'd1, 5'd0, 5'd0, 32'd16, 1'b0);
    cycle();
    in_valid = 1'b0;
    check("after_rst_valid", 32'(out_valid), 32'd1);
    check("after_rst_addr", out_addr, 32'd0);
    cycle();

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      in_fmt      = 3'($urandom_range(0, 7));
      in_funct3   = 3'($urandom_range(0, 7));
      in_rd       = 5'($urandom);
      in_rs1      = 5'($urandom);
      in_rs2      = 5'($urandom);
      in_funct7b5 = 1'($urandom);
      case ($urandom_range(0, 3))
        0: in_imm = 32'($signed($urandom_range(0, 255)) - 128);
        1: in_imm = bimm[$urandom_range(0, 11)];
        2: in_imm = $urandom;
        default: in_imm = 32'($urandom_range(0, 2000)) << 1;
      endcase
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
